// File: rtl/gpio_irq.sv
// gpio_irq -- parametrised GPIO block with a bus-slave register interface.
//
// Purpose: NUM_PINS pins with a 2-bit mode each, an output latch with atomic
// SET/CLR, a 2-flop input synchroniser, an optional debounce filter, and
// per-pin rise/fall edge interrupts with sticky write-1-to-clear status.
//
// Ports:
//   clk       single clock, all state on posedge
//   rst       synchronous reset, active-high
//   we_i      single-cycle write strobe
//   addr_i    byte address, only addr_i[4:0] decoded
//   data_i    write data
//   io_pin_i  raw asynchronous pin inputs
//   io_pin_o  output latch value
//   io_oe_o   1 = pin driven (mode OUTPUT)
//   irq_o     level interrupt, OR of all sticky status bits
//   data_o    combinational read data for addr_i (0 while rst is high)
//
// Register map (addr_i[4:0]):
//   0x00 CTRL  0x04 DATA  0x08 SET  0x0C CLR
//   0x10 IRQ_EN  0x14 IRQ_ST (W1C)  0x18 DEBOUNCE (0 = bypass)
module gpio_irq #(
    parameter int NUM_PINS = 2,
    parameter int DB_W     = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         data_i,
    input  logic [NUM_PINS-1:0] io_pin_i,
    output logic [NUM_PINS-1:0] io_pin_o,
    output logic [NUM_PINS-1:0] io_oe_o,
    output logic                irq_o,
    output logic [31:0]         data_o
);
    localparam int NP = NUM_PINS;

    typedef enum logic [1:0] {
        MODE_HIZ = 2'd0,
        MODE_OUT = 2'd1,
        MODE_IN  = 2'd2,
        MODE_RSV = 2'd3
    } pin_mode_t;

    logic [2*NP-1:0] r_mode;
    logic [NP-1:0]   r_latch;
    logic [NP-1:0]   r_s1;
    logic [NP-1:0]   r_s2;
    logic [NP-1:0]   r_flt;
    logic [NP-1:0]   r_h;
    logic [NP-1:0]   r_rise_en;
    logic [NP-1:0]   r_fall_en;
    logic [NP-1:0]   r_rise_st;
    logic [NP-1:0]   r_fall_st;
    logic [DB_W-1:0] r_db;
    logic [DB_W-1:0] r_cnt;

    logic [4:0]      w_a;
    logic            w_wr_ctrl, w_wr_data, w_wr_set, w_wr_clr;
    logic            w_wr_en, w_wr_st, w_wr_db;
    logic            w_bypass, w_tick;
    logic [NP-1:0]   w_stable, w_flt_nxt;
    logic [NP-1:0]   w_in_mode, w_out_mode;
    logic [NP-1:0]   w_rise, w_fall;
    logic [NP-1:0]   w_clr_rise, w_clr_fall;
    logic [NP-1:0]   w_data_rd;
    logic [31:0]     w_rdata;
    logic            w_unused_bits;

    // Upper address bits and unimplemented data bits are deliberately ignored.
    assign w_unused_bits = ^{addr_i, data_i};

    assign w_a       = addr_i[4:0];
    assign w_wr_ctrl = we_i && (w_a == 5'h00);
    assign w_wr_data = we_i && (w_a == 5'h04);
    assign w_wr_set  = we_i && (w_a == 5'h08);
    assign w_wr_clr  = we_i && (w_a == 5'h0C);
    assign w_wr_en   = we_i && (w_a == 5'h10);
    assign w_wr_st   = we_i && (w_a == 5'h14);
    assign w_wr_db   = we_i && (w_a == 5'h18);

    always_comb begin
        w_in_mode  = '0;
        w_out_mode = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            w_in_mode[i]  = (pin_mode_t'(r_mode[2*i +: 2]) == MODE_IN);
            w_out_mode[i] = (pin_mode_t'(r_mode[2*i +: 2]) == MODE_OUT);
        end
    end

    // Filter: a pin's filtered value only follows s2 when two consecutive
    // prescaler ticks saw the same level (h holds the previous tick's sample).
    assign w_bypass  = (r_db == '0);
    assign w_tick    = !w_bypass && (r_cnt == r_db);
    assign w_stable  = ~(r_s2 ^ r_h);
    always_comb begin
        w_flt_nxt = r_flt;
        if (w_bypass) begin
            w_flt_nxt = r_s2;
        end else if (w_tick) begin
            w_flt_nxt = (r_s2 & w_stable) | (r_flt & ~w_stable);
        end
    end

    // Edges are qualified at the moment flt updates, so flt can track s2 in
    // every mode without a mode change ever looking like an edge.
    assign w_rise     = w_flt_nxt & ~r_flt & w_in_mode & r_rise_en;
    assign w_fall     = ~w_flt_nxt & r_flt & w_in_mode & r_fall_en;
    assign w_clr_rise = w_wr_st ? data_i[NP-1:0]     : '0;
    assign w_clr_fall = w_wr_st ? data_i[16 +: NP]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= '0;
            r_latch   <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_flt     <= '0;
            r_h       <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_rise_st <= '0;
            r_fall_st <= '0;
            r_db      <= '0;
            r_cnt     <= '0;
        end else begin
            r_s1  <= io_pin_i;
            r_s2  <= r_s1;
            r_flt <= w_flt_nxt;

            if (w_wr_db) begin
                r_cnt <= '0;
                r_h   <= r_s2;
            end else begin
                if (w_bypass || w_tick) r_cnt <= '0;
                else                    r_cnt <= r_cnt + DB_W'(1);
                if (w_tick) r_h <= r_s2;
            end

            // New edge is ORed in after the clear, so set wins over W1C.
            r_rise_st <= (r_rise_st & ~w_clr_rise) | w_rise;
            r_fall_st <= (r_fall_st & ~w_clr_fall) | w_fall;

            if (w_wr_ctrl) r_mode <= data_i[2*NP-1:0];
            if (w_wr_data) r_latch <= data_i[NP-1:0];
            if (w_wr_set)  r_latch <= r_latch | data_i[NP-1:0];
            if (w_wr_clr)  r_latch <= r_latch & ~data_i[NP-1:0];
            if (w_wr_en) begin
                r_rise_en <= data_i[NP-1:0];
                r_fall_en <= data_i[16 +: NP];
            end
            if (w_wr_db) r_db <= data_i[DB_W-1:0];
        end
    end

    assign w_data_rd = (w_out_mode & r_latch) | (w_in_mode & r_flt);

    always_comb begin
        w_rdata = '0;
        if (!rst) begin
            case (w_a)
                5'h00: w_rdata[2*NP-1:0] = r_mode;
                5'h04: w_rdata[NP-1:0]   = w_data_rd;
                5'h10: begin
                    w_rdata[NP-1:0]   = r_rise_en;
                    w_rdata[16 +: NP] = r_fall_en;
                end
                5'h14: begin
                    w_rdata[NP-1:0]   = r_rise_st;
                    w_rdata[16 +: NP] = r_fall_st;
                end
                5'h18: w_rdata[DB_W-1:0] = r_db;
                default: w_rdata = '0;
            endcase
        end
    end

    assign data_o   = w_rdata;
    assign io_pin_o = r_latch;
    assign io_oe_o  = w_out_mode;
    assign irq_o    = |{r_rise_st, r_fall_st};
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq -- self-checking bench for gpio_irq (NUM_PINS=4).
// Each cycle is described by a record of inputs and expected outputs; the
// record is queued when driven and popped/compared one edge later.
module tb_gpio_irq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  io_pin_i = '0;
    logic [3:0]  io_pin_o;
    logic [3:0]  io_oe_o;
    logic        irq_o;
    logic [31:0] data_o;

    always #5 clk = ~clk;

    gpio_irq #(.NUM_PINS(4), .DB_W(16), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .io_pin_i (io_pin_i),
        .io_pin_o (io_pin_o),
        .io_oe_o  (io_oe_o),
        .irq_o    (irq_o),
        .data_o   (data_o)
    );

    // m: bit0 pin_o, bit1 oe, bit2 irq, bit3 data
    typedef struct {
        string       nm;
        logic        r;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  pins;
        logic [3:0]  ep;
        logic [3:0]  eo;
        logic        ei;
        logic [31:0] ed;
        logic [3:0]  m;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] cur_pin = '0;
    logic [3:0] cur_oe  = '0;

    function automatic vec_t mk(string nm, logic r, logic we, logic [31:0] a,
                                logic [31:0] d, logic [3:0] pins, logic [3:0] ep,
                                logic [3:0] eo, logic ei, logic [31:0] ed,
                                logic [3:0] m);
        vec_t v;
        v.nm = nm; v.r = r; v.we = we; v.a = a; v.d = d; v.pins = pins;
        v.ep = ep; v.eo = eo; v.ei = ei; v.ed = ed; v.m = m;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clk);
        rst      = v.r;
        we_i     = v.we;
        addr_i   = v.a;
        data_i   = v.d;
        io_pin_i = v.pins;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.m[0]) chk({e.nm, ".pin_o"}, {28'h0, io_pin_o}, {28'h0, e.ep});
        if (e.m[1]) chk({e.nm, ".oe"},    {28'h0, io_oe_o},  {28'h0, e.eo});
        if (e.m[2]) chk({e.nm, ".irq"},   {31'h0, irq_o},    {31'h0, e.ei});
        if (e.m[3]) chk({e.nm, ".data"},  data_o,            e.ed);
    endtask

    task automatic step(string nm, logic we, logic [31:0] a, logic [31:0] d,
                        logic [3:0] pins, logic ei, logic [31:0] ed, logic [3:0] m);
        apply(mk(nm, 1'b0, we, a, d, pins, cur_pin, cur_oe, ei, ed, m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, register readback and bit-masking.
        tbl.push_back(mk("rst",   1, 0, 32'h00, 0, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF));
        tbl.push_back(mk("rst2",  1, 0, 32'h14, 0, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk($sformatf("t1_rd%0h", i*4), 0, 0, 32'(i*4), 0, 4'h0,
                             4'h0, 4'h0, 0, 0, 4'hF));
        tbl.push_back(mk("t1_wr1c", 0, 1, 32'h1C, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF));
        tbl.push_back(mk("t1_rd1c", 0, 0, 32'h1C, 0, 4'h0, 4'h0, 4'h0, 0, 0, 4'hF));
        // Output latch: DATA/SET/CLR.
        tbl.push_back(mk("t2_ctrl",  0, 1, 32'h00, 32'h55, 4'h0, 4'h0, 4'hF, 0, 32'h55, 4'hF));
        tbl.push_back(mk("t2_data",  0, 1, 32'h04, 32'h5,  4'h0, 4'h5, 4'hF, 0, 32'h5,  4'hF));
        tbl.push_back(mk("t2_set",   0, 1, 32'h08, 32'h2,  4'h0, 4'h7, 4'hF, 0, 0,      4'hF));
        tbl.push_back(mk("t2_clr",   0, 1, 32'h0C, 32'h4,  4'h0, 4'h3, 4'hF, 0, 0,      4'hF));
        tbl.push_back(mk("t2_rdd",   0, 0, 32'h04, 0,      4'h0, 4'h3, 4'hF, 0, 32'h3,  4'hF));
        tbl.push_back(mk("t2_en",    0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 4'h3, 4'hF, 0, 32'h000F_000F, 4'hF));
        tbl.push_back(mk("t2_en0",   0, 1, 32'h10, 0,      4'h0, 4'h3, 4'hF, 0, 0,      4'hF));
        tbl.push_back(mk("t2_db",    0, 1, 32'h18, 32'hFFFF_FFFF, 4'h0, 4'h3, 4'hF, 0, 32'hFFFF, 4'hF));
        tbl.push_back(mk("t2_db0",   0, 1, 32'h18, 0,      4'h0, 4'h3, 4'hF, 0, 0,      4'hF));
        // Bypass edge interrupts: flt follows pin three edges later.
        tbl.push_back(mk("t3_ctrl",  0, 1, 32'h00, 32'hAA, 4'h0, 4'h3, 4'h0, 0, 32'hAA, 4'hF));
        tbl.push_back(mk("t3_en",    0, 1, 32'h10, 32'h0001_0001, 4'h0, 4'h3, 4'h0, 0, 32'h0001_0001, 4'hF));
        tbl.push_back(mk("t3_r1",    0, 0, 32'h14, 0, 4'h1, 4'h3, 4'h0, 0, 0,      4'hF));
        tbl.push_back(mk("t3_r2",    0, 0, 32'h14, 0, 4'h1, 4'h3, 4'h0, 0, 0,      4'hF));
        tbl.push_back(mk("t3_r3",    0, 0, 32'h14, 0, 4'h1, 4'h3, 4'h0, 1, 32'h1,  4'hF));
        tbl.push_back(mk("t3_rdd",   0, 0, 32'h04, 0, 4'h1, 4'h3, 4'h0, 1, 32'h1,  4'hF));
        tbl.push_back(mk("t3_f1",    0, 0, 32'h14, 0, 4'h0, 4'h3, 4'h0, 1, 32'h1,  4'hF));
        tbl.push_back(mk("t3_f2",    0, 0, 32'h14, 0, 4'h0, 4'h3, 4'h0, 1, 32'h1,  4'hF));
        tbl.push_back(mk("t3_f3",    0, 0, 32'h14, 0, 4'h0, 4'h3, 4'h0, 1, 32'h1_0001, 4'hF));
        tbl.push_back(mk("t3_w1c",   0, 1, 32'h14, 32'h1_0001, 4'h0, 4'h3, 4'h0, 0, 0, 4'hF));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        cur_pin = 4'h3;
        cur_oe  = 4'h0;

        // Debounce = 3: a one-cycle glitch must not pass; a long pulse must.
        step("t4_en", 1, 32'h10, 32'h1, 4'h0, 0, 32'h1, 4'hF);
        step("t4_db", 1, 32'h18, 32'h3, 4'h0, 0, 32'h3, 4'hF);
        step("t4_g",  0, 32'h04, 0, 4'h1, 0, 0, 4'hF);
        for (int i = 0; i < 16; i++) step("t4_gq", 0, 32'h04, 0, 4'h0, 0, 0, 4'hF);
        for (int i = 0; i < 12; i++) step("t4_h",  0, 32'h14, 0, 4'h1, 0, 0, 4'h3);
        for (int i = 0; i < 12; i++) step("t4_l",  0, 32'h14, 0, 4'h0, 0, 0, 4'h3);
        step("t4_st",  0, 32'h14, 0, 4'h0, 1, 32'h1, 4'hF);
        step("t4_w1c", 1, 32'h14, 32'h1, 4'h0, 0, 0, 4'hF);

        // W1C colliding with a new rise; OUTPUT-mode pin toggling.
        step("t5_db0", 1, 32'h18, 0, 4'h0, 0, 0, 4'hF);
        step("t5_en",  1, 32'h10, 32'h3, 4'h0, 0, 32'h3, 4'hF);
        cur_oe = 4'h2;
        step("t5_ctrl", 1, 32'h00, 32'h6, 4'h0, 0, 32'h6, 4'hF);
        step("t5_r1",  0, 32'h14, 0, 4'h1, 0, 0, 4'hF);
        step("t5_r2",  0, 32'h14, 0, 4'h1, 0, 0, 4'hF);
        step("t5_r3w", 1, 32'h14, 32'h1, 4'h1, 1, 32'h1, 4'hF);
        step("t5_clr", 1, 32'h14, 32'h1, 4'h1, 0, 0, 4'hF);
        for (int i = 0; i < 4; i++) step("t5_p1h", 0, 32'h14, 0, 4'h3, 0, 0, 4'hF);
        for (int i = 0; i < 4; i++) step("t5_p1l", 0, 32'h14, 0, 4'h1, 0, 0, 4'hF);

        // Mode switch with pins already high; reset with an IRQ pending.
        cur_oe = 4'h0;
        step("t6_ctrl0", 1, 32'h00, 0, 4'h1, 0, 0, 4'hF);
        step("t6_en",    1, 32'h10, 32'h000F_000F, 4'h1, 0, 32'h000F_000F, 4'hF);
        for (int i = 0; i < 5; i++) step("t6_hiz", 0, 32'h14, 0, 4'hF, 0, 0, 4'hF);
        step("t6_ctrlin", 1, 32'h00, 32'hAA, 4'hF, 0, 32'hAA, 4'hF);
        for (int i = 0; i < 3; i++) step("t6_in", 0, 32'h14, 0, 4'hF, 0, 0, 4'hF);
        step("t6_rdd", 0, 32'h04, 0, 4'hF, 0, 32'hF, 4'hF);
        step("t6_f1",  0, 32'h14, 0, 4'hB, 0, 0, 4'hF);
        step("t6_f2",  0, 32'h14, 0, 4'hB, 0, 0, 4'hF);
        step("t6_f3",  0, 32'h14, 0, 4'hB, 1, 32'h4_0000, 4'hF);
        apply(mk("t6_rst", 1, 0, 32'h14, 0, 4'hB, 4'h0, 4'h0, 0, 0, 4'hF));
        cur_pin = 4'h0;
        step("t6_post",  0, 32'h14, 0, 4'hB, 0, 0, 4'hF);
        step("t6_postc", 0, 32'h00, 0, 4'hB, 0, 0, 4'hF);
        step("t6_poste", 0, 32'h10, 0, 4'hB, 0, 0, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
